life_ctrl: RTL and testbench

- Consumes the 4-bit user opcode from the PS/2 input stage (0 none, 1 W up, 2 S down, 3 A left, 4 D right, 5 Enter, 6 '=' faster, 7 '-' slower, 8 Space run/pause).
- Produces the cursor position, a cell-toggle strobe, the run/pause state and speed, and the generation-step tick.
- Feeds the grid update engine and the VGA cursor overlay.

---
 rtl/life_pkg.sv | 27 ++
 rtl/life_ctrl_if.sv | 16 +
 rtl/life_tick_gen.sv | 35 +++
 rtl/life_ctrl.sv | 110 +++++++++++
 tb/tb_life_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/life_pkg.sv
// Shared opcode, state and grid-size definitions for the Life controller and
// the PS/2 input stage that feeds it.
package life_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_UP    = 4'd1;
  localparam logic [3:0] OP_DOWN  = 4'd2;
  localparam logic [3:0] OP_LEFT  = 4'd3;
  localparam logic [3:0] OP_RIGHT = 4'd4;
  localparam logic [3:0] OP_ENTER = 4'd5;
  localparam logic [3:0] OP_FAST  = 4'd6;
  localparam logic [3:0] OP_SLOW  = 4'd7;
  localparam logic [3:0] OP_RUN   = 4'd8;

  localparam int LIFE_COLS = 64;
  localparam int LIFE_ROWS = 48;

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic logic is_move(input logic [3:0] op);
    return (op >= OP_UP) && (op <= OP_RIGHT);
  endfunction

endpackage

// File: rtl/life_ctrl_if.sv
// User-opcode input and cursor/run-control outputs of the Life controller.
interface life_ctrl_if #(
  parameter int X_W = 6,
  parameter int Y_W = 6
);
  logic [3:0]     usr_op;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic           toggle;
  logic           running;
  logic [2:0]     speed;
  logic           step;

  modport master (output usr_op, input cur_x, cur_y, toggle, running, speed, step);
  modport slave  (input usr_op, output cur_x, cur_y, toggle, running, speed, step);
endinterface

// File: rtl/life_tick_gen.sv
// Generation-step tick: period TICK_BASE >> speed, one-cycle step on each wrap.
module life_tick_gen #(
  parameter int TICK_BASE = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] speed,
  input  logic       running,
  input  logic       clear,
  output logic       step
);

  logic [31:0] period;
  logic [31:0] cnt;

  assign period = 32'(TICK_BASE) >> speed;

  // clear has priority so a run/pause change or speed change never emits a step
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      step <= 1'b0;
    end else if (clear || !running) begin
      cnt  <= '0;
      step <= 1'b0;
    end else if (cnt >= period - 32'd1) begin
      cnt  <= '0;
      step <= 1'b1;
    end else begin
      cnt  <= cnt + 32'd1;
      step <= 1'b0;
    end
  end

endmodule

// File: rtl/life_ctrl.sv
// Life user controller: key-edge detection, cursor movement with auto-repeat,
// cell toggle, run/pause and speed control, generation tick.
module life_ctrl
  import life_pkg::*;
#(
  parameter int COLS      = LIFE_COLS,
  parameter int ROWS      = LIFE_ROWS,
  parameter int X_W       = 6,
  parameter int Y_W       = 6,
  parameter int TICK_BASE = 50000000,
  parameter int RPT_DELAY = 25000000,
  parameter int RPT_RATE  = 5000000
) (
  input logic        clk,
  input logic        rst,
  life_ctrl_if.slave bus
);

  localparam logic [X_W-1:0] X_LAST     = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST     = Y_W'(ROWS - 1);
  localparam logic [31:0]    RPT_LAST   = 32'(RPT_DELAY - 1);
  localparam logic [31:0]    RPT_RELOAD = 32'(RPT_DELAY - RPT_RATE);

  state_t         state;
  logic [3:0]     op_prev;
  logic [31:0]    rpt_cnt;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic           toggle;
  logic [2:0]     speed;
  logic           step;

  logic press, held_move, rpt_fire, do_move, run_tog, spd_up, spd_dn, tick_clr;

  always_comb begin
    press     = 1'b0;
    held_move = 1'b0;
    rpt_fire  = 1'b0;
    do_move   = 1'b0;
    run_tog   = 1'b0;
    spd_up    = 1'b0;
    spd_dn    = 1'b0;
    press     = (bus.usr_op != OP_NONE) && (bus.usr_op != op_prev);
    held_move = (bus.usr_op == op_prev) && is_move(op_prev);
    rpt_fire  = held_move && (rpt_cnt == RPT_LAST);
    do_move   = (press && is_move(bus.usr_op)) || rpt_fire;
    run_tog   = press && (bus.usr_op == OP_RUN);
    spd_up    = press && (bus.usr_op == OP_FAST) && (speed != 3'd7);
    spd_dn    = press && (bus.usr_op == OP_SLOW) && (speed != 3'd0);
    tick_clr  = run_tog || spd_up || spd_dn;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_PAUSE;
      op_prev <= OP_NONE;
      rpt_cnt <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      toggle  <= 1'b0;
      speed   <= '0;
    end else begin
      op_prev <= bus.usr_op;
      toggle  <= 1'b0;

      if (press)          rpt_cnt <= '0;
      else if (rpt_fire)  rpt_cnt <= RPT_RELOAD;
      else if (held_move) rpt_cnt <= rpt_cnt + 32'd1;
      else                rpt_cnt <= '0;

      // a repeat only fires while usr_op equals op_prev, so usr_op names the move
      if (do_move) begin
        case (bus.usr_op)
          OP_UP:    cur_y <= (cur_y == '0)     ? Y_LAST : cur_y - 1'b1;
          OP_DOWN:  cur_y <= (cur_y == Y_LAST) ? '0     : cur_y + 1'b1;
          OP_LEFT:  cur_x <= (cur_x == '0)     ? X_LAST : cur_x - 1'b1;
          OP_RIGHT: cur_x <= (cur_x == X_LAST) ? '0     : cur_x + 1'b1;
          default:  ;
        endcase
      end

      if (press) begin
        case (bus.usr_op)
          OP_ENTER: if (state == ST_PAUSE) toggle <= 1'b1;
          OP_FAST:  if (spd_up) speed <= speed + 3'd1;
          OP_SLOW:  if (spd_dn) speed <= speed - 3'd1;
          OP_RUN:   state <= (state == ST_RUN) ? ST_PAUSE : ST_RUN;
          default:  ;
        endcase
      end
    end
  end

  life_tick_gen #(.TICK_BASE(TICK_BASE)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .speed   (speed),
    .running (state == ST_RUN),
    .clear   (tick_clr),
    .step    (step)
  );

  assign bus.cur_x   = cur_x;
  assign bus.cur_y   = cur_y;
  assign bus.toggle  = toggle;
  assign bus.running = (state == ST_RUN);
  assign bus.speed   = speed;
  assign bus.step    = step;

endmodule

// File: tb/tb_life_ctrl.sv
// Directed + randomized bench for life_ctrl against a behavioural model.
module tb_life_ctrl;

  localparam int COLS = 64;
  localparam int ROWS = 48;
  localparam int TB   = 128;
  localparam int RD   = 20;
  localparam int RR   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  life_ctrl_if #(.X_W(6), .Y_W(6)) bus ();

  life_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .X_W(6), .Y_W(6),
    .TICK_BASE(TB), .RPT_DELAY(RD), .RPT_RATE(RR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_prev, m_held, m_x, m_y, m_tog, m_run, m_spd, m_step, m_phase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_held = 0; m_x = 0; m_y = 0; m_tog = 0;
    m_run = 0; m_spd = 0; m_step = 0; m_phase = 0;
  endtask

  task automatic model_update(input int op);
    bit press, mv, rep, spd_chg, sp;
    int period;
    press = (op != 0) && (op != m_prev);
    mv    = (op >= 1) && (op <= 4);
    if (press) m_held = 0;
    else if (op == m_prev && mv) m_held++;
    else m_held = 0;
    rep = !press && (op == m_prev) && mv && (m_held >= RD) && ((m_held - RD) % RR == 0);
    period  = TB >> m_spd;
    spd_chg = press && ((op == 6 && m_spd < 7) || (op == 7 && m_spd > 0));
    sp      = press && (op == 8);
    if (sp || spd_chg || !m_run) begin
      m_phase = 0; m_step = 0;
    end else begin
      m_phase++;
      m_step = (m_phase % period == 0) ? 1 : 0;
    end
    m_tog = (press && op == 5 && !m_run) ? 1 : 0;
    if ((press && mv) || rep) begin
      case (op)
        1: m_y = (m_y == 0) ? ROWS - 1 : m_y - 1;
        2: m_y = (m_y == ROWS - 1) ? 0 : m_y + 1;
        3: m_x = (m_x == 0) ? COLS - 1 : m_x - 1;
        4: m_x = (m_x == COLS - 1) ? 0 : m_x + 1;
        default: ;
      endcase
    end
    if (spd_chg) m_spd = (op == 6) ? m_spd + 1 : m_spd - 1;
    if (sp) m_run = !m_run;
    m_prev = op;
  endtask

  task automatic check_all();
    chk("cur_x",   32'(bus.cur_x),   32'(m_x));
    chk("cur_y",   32'(bus.cur_y),   32'(m_y));
    chk("toggle",  32'(bus.toggle),  32'(m_tog));
    chk("running", 32'(bus.running), 32'(m_run));
    chk("speed",   32'(bus.speed),   32'(m_spd));
    chk("step",    32'(bus.step),    32'(m_step));
  endtask

  task automatic cyc(input int op);
    bus.usr_op = 4'(op);
    @(posedge clk);
    model_update(op);
    #1;
    check_all();
  endtask

  task automatic pulse(input int op);
    cyc(op);
    cyc(0);
  endtask

  task automatic do_reset(input int n, input int op);
    rst = 1'b0;
    bus.usr_op = 4'(op);
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    chk("rst_cur_x",   32'(bus.cur_x),   0);
    chk("rst_cur_y",   32'(bus.cur_y),   0);
    chk("rst_toggle",  32'(bus.toggle),  0);
    chk("rst_running", 32'(bus.running), 0);
    chk("rst_speed",   32'(bus.speed),   0);
    chk("rst_step",    32'(bus.step),    0);
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tcount, stepc, first, op, len;
    bus.usr_op = 4'd0;
    model_reset();

    // reset with D held, one move only
    do_reset(3, 4);
    cyc(4);
    chk("hold_through_reset_x", 32'(bus.cur_x), 1);
    repeat (19) cyc(4);
    chk("no_early_repeat_x", 32'(bus.cur_x), 1);
    cyc(0);

    // wrap-around boundaries
    pulse(3);
    pulse(3);
    chk("wrap_left_x", 32'(bus.cur_x), 63);
    pulse(4);
    chk("wrap_right_x", 32'(bus.cur_x), 0);
    pulse(1);
    chk("wrap_up_y", 32'(bus.cur_y), 47);
    pulse(2);
    chk("wrap_down_y", 32'(bus.cur_y), 0);
    pulse(1);
    chk("wrap_up_y2", 32'(bus.cur_y), 47);

    // auto-repeat from x=0
    repeat (40) cyc(4);
    chk("repeat_final_x", 32'(bus.cur_x), 5);
    cyc(0);

    // walk to (10,7) and toggle with Enter held
    for (int i = 0; i < 64 && m_x != 10; i++) pulse(4);
    for (int i = 0; i < 64 && m_y != 7; i++) pulse(2);
    tcount = 0;
    repeat (10) begin
      cyc(5);
      tcount += int'(bus.toggle);
    end
    chk("enter_toggle_once", 32'(tcount), 1);
    chk("enter_x", 32'(bus.cur_x), 10);
    chk("enter_y", 32'(bus.cur_y), 7);
    cyc(0);
    cyc(8);
    cyc(0);
    cyc(5);
    chk("run_enter_running", 32'(bus.running), 1);
    chk("run_enter_no_toggle", 32'(bus.toggle), 0);
    cyc(0);

    // speed 0: period 128
    stepc = 0;
    repeat (300) begin
      cyc(0);
      stepc += int'(bus.step);
    end
    chk("steps_speed0", 32'(stepc), 2);

    // speed 2: first step 32 cycles after the second press
    pulse(6);
    cyc(6);
    first = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc(0);
      if (bus.step && first == 0) first = i;
    end
    chk("first_step_speed2", 32'(first), 32);
    chk("speed2", 32'(bus.speed), 2);

    // speed 7: period 1
    repeat (5) pulse(6);
    cyc(6);
    stepc = 0;
    repeat (10) begin
      cyc(0);
      stepc += int'(bus.step);
    end
    chk("steps_speed7", 32'(stepc), 10);
    pulse(6);
    chk("speed_sat_hi", 32'(bus.speed), 7);

    // back to speed 0, then Space exactly on a counter wrap
    repeat (7) pulse(7);
    for (int i = 0; i < 200 && m_phase != TB - 1; i++) cyc(0);
    chk("wait_for_wrap", 32'(m_phase), 32'(TB - 1));
    cyc(8);
    chk("space_on_wrap_running", 32'(bus.running), 0);
    chk("space_on_wrap_step", 32'(bus.step), 0);
    cyc(0);

    // saturated '-' at speed 0 leaves the tick counter running
    cyc(8);
    first = 0;
    for (int i = 1; i <= 200; i++) begin
      cyc((i == 50) ? 7 : 0);
      if (bus.step && first == 0) first = i;
    end
    chk("slow_sat_no_clear", 32'(first), 128);
    chk("speed_sat_lo", 32'(bus.speed), 0);

    // randomized held keys, with one reset in the middle of a hold
    for (int s = 0; s < 80; s++) begin
      op  = int'($urandom_range(0, 15));
      len = int'($urandom_range(1, 35));
      if (s == 40) begin
        repeat (len) cyc(4);
        do_reset(2, 4);
      end
      repeat (len) cyc(op);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
